// File: rtl/adxl362_sequencer.sv
// rtl/adxl362_sequencer.sv - ADXL362 register sequencer: init write, periodic XYZ bursts, manual access
module adxl362_sequencer #(
  parameter int          CLK_FREQUENCY  = 100_000_000,
  parameter int          SAMPLE_RATE    = 2,
  parameter logic [7:0]  INIT_ADDR      = 8'h2D,
  parameter logic [7:0]  INIT_DATA      = 8'h02,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       man_wr_req,
  input  logic       man_rd_req,
  input  logic [7:0] man_addr,
  input  logic [7:0] man_wdata,
  input  logic       ctrl_busy,
  input  logic       ctrl_done,
  input  logic [7:0] ctrl_rdata,
  output logic       ctrl_start,
  output logic       ctrl_write,
  output logic [7:0] ctrl_addr,
  output logic [7:0] ctrl_wdata,
  output logic [7:0] man_rdata,
  output logic       man_rdata_valid,
  output logic [7:0] x_data,
  output logic [7:0] y_data,
  output logic [7:0] z_data,
  output logic       xyz_valid,
  output logic       init_done,
  output logic       req_dropped,
  output logic       timeout_err
);

  localparam int SAMPLE_PERIOD = CLK_FREQUENCY / SAMPLE_RATE;
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] TO_MAX    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    AXIS_BASE = 8'h08;

  typedef enum logic [2:0] {INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT_DONE} state_t;
  state_t state, state_next;

  logic          pend_valid, pend_write;
  logic [7:0]    pend_addr, pend_wdata;
  logic          auto_pending;
  logic [1:0]    axis;
  logic [TW-1:0] timer;
  logic [CW-1:0] to_cnt;
  logic          cur_manual;

  logic init_start, init_ok, init_timeout;
  logic sel_manual, sel_auto, xfer_done, xfer_timeout;
  logic auto_clear, timer_hit, slot_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT_ISSUE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    init_start   = 1'b0;
    init_ok      = 1'b0;
    init_timeout = 1'b0;
    sel_manual   = 1'b0;
    sel_auto     = 1'b0;
    xfer_done    = 1'b0;
    xfer_timeout = 1'b0;
    case (state)
      INIT_ISSUE: if (!ctrl_busy) begin
        init_start = 1'b1;
        state_next = INIT_WAIT;
      end
      INIT_WAIT: if (ctrl_done) begin
        init_ok    = 1'b1;
        state_next = IDLE;
      end else if (to_cnt == TO_MAX) begin
        init_timeout = 1'b1;
        state_next   = INIT_ISSUE;
      end
      // Manual slot has priority over the automatic burst.
      IDLE: if (!ctrl_busy) begin
        if (pend_valid) begin
          sel_manual = 1'b1;
          state_next = ISSUE;
        end else if (auto_pending) begin
          sel_auto   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT_DONE;
      WAIT_DONE: if (ctrl_done) begin
        xfer_done  = 1'b1;
        state_next = IDLE;
      end else if (to_cnt == TO_MAX) begin
        xfer_timeout = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = INIT_ISSUE;
    endcase
  end

  assign auto_clear = (xfer_done || xfer_timeout) && !cur_manual && (axis == 2'd2);
  assign timer_hit  = init_done && (timer == TIMER_MAX);
  assign slot_busy  = pend_valid && !sel_manual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_start      <= 1'b0;
      ctrl_write      <= 1'b0;
      ctrl_addr       <= 8'h00;
      ctrl_wdata      <= 8'h00;
      cur_manual      <= 1'b0;
      man_rdata       <= 8'h00;
      man_rdata_valid <= 1'b0;
      x_data          <= 8'h00;
      y_data          <= 8'h00;
      z_data          <= 8'h00;
      xyz_valid       <= 1'b0;
      init_done       <= 1'b0;
      timeout_err     <= 1'b0;
      axis            <= 2'd0;
    end else begin
      ctrl_start      <= init_start || sel_manual || sel_auto;
      man_rdata_valid <= 1'b0;
      xyz_valid       <= 1'b0;
      timeout_err     <= init_timeout || xfer_timeout;
      if (init_start) begin
        ctrl_write <= 1'b1;
        ctrl_addr  <= INIT_ADDR;
        ctrl_wdata <= INIT_DATA;
        cur_manual <= 1'b0;
      end else if (sel_manual) begin
        ctrl_write <= pend_write;
        ctrl_addr  <= pend_addr;
        ctrl_wdata <= pend_wdata;
        cur_manual <= 1'b1;
      end else if (sel_auto) begin
        ctrl_write <= 1'b0;
        ctrl_addr  <= AXIS_BASE + {6'd0, axis};
        ctrl_wdata <= 8'h00;
        cur_manual <= 1'b0;
      end
      if (init_ok) init_done <= 1'b1;
      if (xfer_done) begin
        if (cur_manual) begin
          if (!ctrl_write) begin
            man_rdata       <= ctrl_rdata;
            man_rdata_valid <= 1'b1;
          end
        end else begin
          case (axis)
            2'd0:    x_data <= ctrl_rdata;
            2'd1:    y_data <= ctrl_rdata;
            default: begin
              z_data    <= ctrl_rdata;
              xyz_valid <= 1'b1;
            end
          endcase
        end
      end
      // A timed-out axis is skipped so the burst still completes.
      if ((xfer_done || xfer_timeout) && !cur_manual)
        axis <= (axis == 2'd2) ? 2'd0 : axis + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid  <= 1'b0;
      pend_write  <= 1'b0;
      pend_addr   <= 8'h00;
      pend_wdata  <= 8'h00;
      req_dropped <= 1'b0;
    end else begin
      req_dropped <= 1'b0;
      if (sel_manual) pend_valid <= 1'b0;
      if (man_wr_req || man_rd_req) begin
        if (slot_busy) begin
          req_dropped <= 1'b1;
        end else begin
          pend_valid  <= 1'b1;
          pend_write  <= man_wr_req;
          pend_addr   <= man_addr;
          pend_wdata  <= man_wr_req ? man_wdata : 8'h00;
          req_dropped <= man_wr_req && man_rd_req;
        end
      end
    end
  end

  // Expiry wins over clear so a period ending as Z completes is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      auto_pending <= 1'b0;
      to_cnt       <= '0;
    end else begin
      if (init_done) timer <= timer_hit ? '0 : timer + 1'b1;
      if (auto_clear) auto_pending <= 1'b0;
      if (timer_hit)  auto_pending <= 1'b1;
      if (state == INIT_WAIT || state == WAIT_DONE) to_cnt <= to_cnt + 1'b1;
      else                                          to_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_adxl362_sequencer.sv
// tb/tb_adxl362_sequencer.sv - directed bench for adxl362_sequencer with a 20-cycle controller model
module tb_adxl362_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       man_wr_req = 1'b0, man_rd_req = 1'b0;
  logic [7:0] man_addr = 8'h00, man_wdata = 8'h00;
  logic       ctrl_busy, ctrl_done;
  logic [7:0] ctrl_rdata;
  logic       ctrl_start, ctrl_write;
  logic [7:0] ctrl_addr, ctrl_wdata, man_rdata, x_data, y_data, z_data;
  logic       man_rdata_valid, xyz_valid, init_done, req_dropped, timeout_err;

  adxl362_sequencer #(
    .CLK_FREQUENCY(1000), .SAMPLE_RATE(10), .INIT_ADDR(8'h2D),
    .INIT_DATA(8'h02), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .man_wr_req(man_wr_req), .man_rd_req(man_rd_req),
    .man_addr(man_addr), .man_wdata(man_wdata),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata),
    .ctrl_start(ctrl_start), .ctrl_write(ctrl_write),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .man_rdata(man_rdata), .man_rdata_valid(man_rdata_valid),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .xyz_valid(xyz_valid), .init_done(init_done),
    .req_dropped(req_dropped), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0, failures = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int log_target = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (req_dropped) drop_cnt++;

  // Controller model: busy for 20 cycles after ctrl_start, then a done pulse.
  logic       m_busy = 1'b0, m_done = 1'b0, inj_done = 1'b0, hang = 1'b0;
  logic [7:0] m_rdata = 8'h00, m_addr = 8'h00;
  logic [7:0] rx = 8'h11, ry = 8'h22, rz = 8'h33;
  int         m_cnt = 0, m_done_cyc = 0;
  logic [7:0] la[$], ld[$];
  logic       lw[$];
  int         lc[$];

  assign ctrl_busy  = m_busy;
  assign ctrl_done  = m_done | inj_done;
  assign ctrl_rdata = inj_done ? 8'h99 : m_rdata;

  function automatic logic [7:0] resp(input logic [7:0] a);
    case (a)
      8'h08:   return rx;
      8'h09:   return ry;
      8'h0A:   return rz;
      8'h00:   return 8'hAD;
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          if (!(hang && m_addr == 8'h09)) begin
            m_done = 1'b1; m_rdata = resp(m_addr); m_done_cyc = cyc;
          end
        end
      end
      if (ctrl_start) begin
        m_busy = 1'b1; m_cnt = 20; m_addr = ctrl_addr;
        la.push_back(ctrl_addr); lw.push_back(ctrl_write);
        ld.push_back(ctrl_wdata); lc.push_back(cyc);
      end
    end
  end

  function automatic logic [7:0] la_at(input int i);
    return (i >= 0 && i < la.size()) ? la[i] : 8'hxx;
  endfunction
  function automatic logic [7:0] ld_at(input int i);
    return (i >= 0 && i < ld.size()) ? ld[i] : 8'hxx;
  endfunction
  function automatic logic lw_at(input int i);
    return (i >= 0 && i < lw.size()) ? lw[i] : 1'bx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return init_done === 1'b1;
      1:       return xyz_valid === 1'b1;
      2:       return man_rdata_valid === 1'b1;
      3:       return timeout_err === 1'b1;
      default: return la.size() >= log_target;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int budget, input string tag);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = cond(which);
    end
    chk({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    int t1, yi, idx, n, ones;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_init_done", init_done, 0);
    chk("rst_ctrl_start", ctrl_start, 0);
    chk("rst_ctrl_addr", ctrl_addr, 0);
    chk("rst_x_data", x_data, 0);
    chk("rst_xyz_valid", xyz_valid, 0);
    chk("rst_req_dropped", req_dropped, 0);
    rst_n = 1'b1;

    // Manual write before init_done must be held, not dropped
    @(negedge clk); man_wr_req = 1'b1; man_addr = 8'h1F; man_wdata = 8'h52;
    @(negedge clk); man_wr_req = 1'b0;
    wait_cond(0, 200, "init");
    chk("init_addr", la_at(0), 8'h2D);
    chk("init_write", lw_at(0), 1);
    chk("init_wdata", ld_at(0), 8'h02);
    chk("init_latency", cyc - m_done_cyc, 1);
    log_target = 2;
    wait_cond(4, 100, "early_wr");
    chk("early_wr_addr", la_at(1), 8'h1F);
    chk("early_wr_write", lw_at(1), 1);
    chk("early_wr_wdata", ld_at(1), 8'h52);

    // First automatic burst
    wait_cond(1, 300, "burst1");
    chk("b1_x", x_data, 8'h11);
    chk("b1_y", y_data, 8'h22);
    chk("b1_z", z_data, 8'h33);
    chk("b1_order_x", la_at(2), 8'h08);
    chk("b1_order_y", la_at(3), 8'h09);
    chk("b1_order_z", la_at(4), 8'h0A);
    chk("b1_rd_wdata", ld_at(3), 8'h00);
    chk("b1_rd_write", lw_at(4), 0);
    chk("xyz_latency", cyc - m_done_cyc, 1);
    t1 = cyc;
    @(negedge clk);
    chk("xyz_pulse_width", xyz_valid, 0);
    wait_cond(1, 150, "burst2");
    chk("burst_period", cyc - t1, 100);

    // Manual read interleaved between Y and Z
    log_target = la.size() + 2;
    wait_cond(4, 200, "y_start");
    yi = log_target - 1;
    @(negedge clk); man_rd_req = 1'b1; man_addr = 8'h00;
    @(negedge clk); man_rd_req = 1'b0;
    wait_cond(2, 200, "man_rd");
    chk("man_rdata", man_rdata, 8'hAD);
    chk("man_rd_latency", cyc - m_done_cyc, 1);
    wait_cond(1, 100, "burst3");
    chk("il_y", la_at(yi), 8'h09);
    chk("il_man", la_at(yi + 1), 8'h00);
    chk("il_man_write", lw_at(yi + 1), 0);
    chk("il_z", la_at(yi + 2), 8'h0A);
    chk("il_z_data", z_data, 8'h33);

    // ctrl_done outside a wait state is ignored
    @(negedge clk); inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    chk("stray_done_valid", man_rdata_valid, 0);
    chk("stray_done_rdata", man_rdata, 8'hAD);
    chk("stray_done_xyz", xyz_valid, 0);

    // Simultaneous write+read, then a second request while the slot is full
    chk("drops_before", drop_cnt, 0);
    log_target = la.size() + 1;
    wait_cond(4, 200, "xfer_start");
    @(negedge clk);
    man_wr_req = 1'b1; man_rd_req = 1'b1; man_addr = 8'h20; man_wdata = 8'h5A;
    @(negedge clk);
    man_wr_req = 1'b0; man_rd_req = 1'b0;
    chk("drop_same_cycle", req_dropped, 1);
    man_rd_req = 1'b1; man_addr = 8'h01;
    @(negedge clk);
    man_rd_req = 1'b0;
    chk("drop_slot_full", req_dropped, 1);
    idx = la.size();
    log_target = idx + 1;
    wait_cond(4, 100, "man_wr");
    chk("man_wr_addr", la_at(idx), 8'h20);
    chk("man_wr_write", lw_at(idx), 1);
    chk("man_wr_wdata", ld_at(idx), 8'h5A);
    repeat (120) @(negedge clk);
    ones = 0;
    for (int i = 0; i < la.size(); i++) if (la[i] == 8'h01) ones++;
    chk("dropped_rd_absent", ones, 0);
    chk("drop_count", drop_cnt, 2);

    // Y never completes: timeout, Z follows, y_data keeps its old value
    wait_cond(1, 200, "pre_hang");
    hang = 1'b1; rx = 8'h44; rz = 8'h66;
    wait_cond(3, 300, "timeout");
    yi = -1;
    for (int i = 0; i < la.size(); i++) if (la[i] == 8'h09) yi = i;
    chk("timeout_delay", cyc - ((yi >= 0) ? lc[yi] : 0), 51);
    @(negedge clk);
    chk("timeout_pulse_width", timeout_err, 0);
    wait_cond(1, 200, "burst_to");
    chk("to_x", x_data, 8'h44);
    chk("to_y_kept", y_data, 8'h22);
    chk("to_z", z_data, 8'h66);
    chk("to_next_z", la_at(yi + 1), 8'h0A);
    hang = 1'b0; rx = 8'h11; rz = 8'h33;

    // Reset during an X read
    log_target = la.size() + 1;
    wait_cond(4, 200, "x_start");
    chk("x_start_addr", la_at(la.size() - 1), 8'h08);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", x_data, 0);
    chk("mid_rst_z", z_data, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_man_rdata", man_rdata, 0);
    chk("mid_rst_ctrl_addr", ctrl_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = la.size();
    log_target = n + 1;
    wait_cond(4, 100, "reinit");
    chk("reinit_addr", la_at(n), 8'h2D);
    chk("reinit_write", lw_at(n), 1);
    chk("reinit_wdata", ld_at(n), 8'h02);
    wait_cond(0, 100, "reinit_done");
    chk("reinit_x_zero", x_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/adxl362_sequencer.md
ADXL362_SEQUENCER -- requirements
Module: adxl362_sequencer

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 2, automatic XYZ bursts per second; SAMPLE_PERIOD = CLK_FREQUENCY/SAMPLE_RATE cycles.
REQ-003 SHALL have parameter INIT_ADDR, default 8'h2D, register written once after reset (POWER_CTL).
REQ-004 SHALL have parameter INIT_DATA, default 8'h02, value written to INIT_ADDR (measurement mode).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum cycles waiting for ctrl_done.
REQ-006 clk  input  1  system clock; all state changes on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 man_wr_req / man_rd_req  input  1 each  one-cycle manual write/read request pulses.
REQ-009 man_addr / man_wdata  input  8 each  manual address / write data, sampled with the request.
REQ-010 ctrl_busy / ctrl_done  input  1 each  SPI controller busy level / one-cycle completion pulse.
REQ-011 ctrl_rdata  input  8  SPI controller read data, valid with ctrl_done.
REQ-012 ctrl_start  output  1  one-cycle transfer start to SPI controller.
REQ-013 ctrl_write / ctrl_addr / ctrl_wdata  output  1/8/8  transfer type (1=write), address, write data.
REQ-014 man_rdata  output  8  last manual read result; man_rdata_valid  output  1  pulse when updated.
REQ-015 x_data / y_data / z_data  output  8 each  last automatic axis readings (regs 0x08/0x09/0x0A).
REQ-016 xyz_valid  output  1  pulse when z_data of a burst is written.
REQ-017 init_done  output  1  level, high once the init write completed.
REQ-018 req_dropped / timeout_err  output  1 each  pulses: manual request discarded / transfer timed out.

Function
REQ-019 FSM states SHALL be INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, WAIT_DONE.
REQ-020 After reset SHALL enter INIT_ISSUE, wait for ctrl_busy low, issue write INIT_ADDR/INIT_DATA, go INIT_WAIT; on ctrl_done set init_done and go IDLE.
REQ-021 Manual requests SHALL be latched into a one-deep pending slot in any state; requests before init_done SHALL be held, not dropped.
REQ-022 Request arriving while slot full SHALL be discarded with req_dropped pulse; man_wr_req and man_rd_req in same cycle SHALL keep write, drop read, pulse req_dropped.
REQ-023 Sample timer SHALL start at init_done and set auto_pending every SAMPLE_PERIOD cycles; expiry while auto_pending set SHALL leave it set (no queueing).
REQ-024 In IDLE with ctrl_busy low: manual pending SHALL win over auto; auto burst issues X, then Y, then Z, returning through IDLE after each axis, so a manual transfer MAY interleave between axes; auto_pending clears after Z.
REQ-025 In ISSUE ctrl_start SHALL be high exactly one cycle; next state WAIT_DONE.
REQ-026 ctrl_write/ctrl_addr/ctrl_wdata SHALL be set on entry to ISSUE and stay stable until leaving WAIT_DONE; ctrl_wdata = 0 for reads.
REQ-027 In WAIT_DONE on ctrl_done SHALL route ctrl_rdata to man_rdata (+man_rdata_valid) or the axis register (+xyz_valid for Z); writes update no data output; next state IDLE.
REQ-028 Latency: IDLE selection to ctrl_start SHALL be 1 cycle; ctrl_done to data output/valid pulse SHALL be 1 cycle.
REQ-029 If WAIT_DONE/INIT_WAIT lasts TIMEOUT_CYCLES without ctrl_done SHALL pulse timeout_err, discard that transfer (auto burst advances to next axis; init retries INIT_ISSUE).
REQ-030 ctrl_done outside WAIT_DONE/INIT_WAIT SHALL be ignored.

Reset
REQ-031 rst_n low SHALL immediately clear all outputs, pending slot, auto_pending, timer, timeout counter; FSM to INIT_ISSUE.
REQ-032 Reset mid-transfer SHALL abandon it; init write SHALL reissue after release.

Verification
REQ-033 CLK_FREQUENCY=1000, SAMPLE_RATE=10, controller model 20-cycle transfers: release reset -> write 0x2D/0x02 first, init_done high after its done.
REQ-034 Model returns 0x11/0x22/0x33 for 0x08/0x09/0x0A -> x/y/z = 0x11/0x22/0x33, xyz_valid once per 100 cycles.
REQ-035 man_rd_req addr 0x00 during Y transfer, model returns 0xAD -> read of 0x00 issued after Y, before Z; man_rdata=0xAD.
REQ-036 man_wr_req and man_rd_req same cycle, then second request while pending -> one write issued, req_dropped pulses twice.
REQ-037 Model never asserts ctrl_done on 0x09, TIMEOUT_CYCLES=50 -> timeout_err after 50 cycles, Z read follows, y_data unchanged.
REQ-038 rst_n low mid X read -> outputs zero at once; after release init write reissued.
